calc_self_test: RTL and testbench

- Hardware stimulus-and-check engine for the low-power 4-bit calculator (lp_calc_top).
- Drives the calculator's a/b/op inputs through an ordered vector sweep and samples its 8-bit result after a settle window.
- Compares each sampled result against an internal reference model, counts mismatches and captures the first failing vector.
- Sits beside lp_calc_top as its initiator and result reader; intended for on-chip power-on self test.

---
 rtl/calc_self_test.sv | 170 +++++++++++++++++
 tb/tb_calc_self_test.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/calc_self_test.sv
// Power-on self-test engine for lp_calc_top: sweeps every a/b/op vector, samples the
// calculator result after a settle window and checks it against a reference model.
module calc_self_test #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned NUM_VECTORS   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  result_in,
  output logic [3:0]  a_out,
  output logic [3:0]  b_out,
  output logic [1:0]  op_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [10:0] err_count,
  output logic [3:0]  fail_a,
  output logic [3:0]  fail_b,
  output logic [1:0]  fail_op,
  output logic [7:0]  fail_result
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [9:0] IDX_LAST = 10'(NUM_VECTORS - 1);

  logic [1:0]  state_q, state_d;
  logic [9:0]  idx_q, idx_d, idx_next;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  a_q, a_d, b_q, b_d, fail_a_q, fail_a_d, fail_b_q, fail_b_d;
  logic [1:0]  op_q, op_d, fail_op_q, fail_op_d;
  logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [10:0] err_q, err_d, err_next;
  logic [7:0]  fail_res_q, fail_res_d;
  logic        mismatch;

  function automatic logic [7:0] expected(input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] op);
    logic [7:0] r;
    unique case (op)
      2'b00: r = {4'd0, a} + {4'd0, b};
      2'b01: r = {4'd0, a} - {4'd0, b};
      2'b10: r = {4'd0, a} * {4'd0, b};
      default: r = (b == 4'd0) ? 8'hFF : {4'd0, a / b};
    endcase
    return r;
  endfunction

  assign mismatch = (result_in != expected(a_q, b_q, op_q));
  assign idx_next = idx_q + 10'd1;

  // Saturating error count; only applied on a sample edge.
  always_comb begin
    err_next = err_q;
    if (mismatch && err_q != 11'h7FF) err_next = err_q + 11'd1;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_d      = err_q;
    fail_a_d   = fail_a_q;
    fail_b_d   = fail_b_q;
    fail_op_d  = fail_op_q;
    fail_res_d = fail_res_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RUN;
          idx_d      = 10'd0;
          cnt_d      = 8'd0;
          a_d        = 4'd0;
          b_d        = 4'd0;
          op_d       = 2'd0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          err_d      = 11'd0;
          fail_a_d   = 4'd0;
          fail_b_d   = 4'd0;
          fail_op_d  = 2'd0;
          fail_res_d = 8'd0;
        end
      end
      RUN: begin
        if (cnt_q < CNT_LAST) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          err_d = err_next;
          if (mismatch && err_q == 11'd0) begin
            fail_a_d   = a_q;
            fail_b_d   = b_q;
            fail_op_d  = op_q;
            fail_res_d = result_in;
          end
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_next == 11'd0);
          end else begin
            // b is the low nibble of idx, so consecutive vectors always differ.
            idx_d              = idx_next;
            {op_d, a_d, b_d}   = idx_next;
            cnt_d              = 8'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= 10'd0;
      cnt_q      <= 8'd0;
      a_q        <= 4'd0;
      b_q        <= 4'd0;
      op_q       <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= 11'd0;
      fail_a_q   <= 4'd0;
      fail_b_q   <= 4'd0;
      fail_op_q  <= 2'd0;
      fail_res_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      fail_a_q   <= fail_a_d;
      fail_b_q   <= fail_b_d;
      fail_op_q  <= fail_op_d;
      fail_res_q <= fail_res_d;
    end
  end

  assign a_out       = a_q;
  assign b_out       = b_q;
  assign op_out      = op_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_count   = err_q;
  assign fail_a      = fail_a_q;
  assign fail_b      = fail_b_q;
  assign fail_op     = fail_op_q;
  assign fail_result = fail_res_q;

endmodule

// File: tb/tb_calc_self_test.sv
// Directed bench for calc_self_test: a behavioural calculator with selectable faults,
// a table of full sweeps, and hand sequences for restart, reset and the 1x1 corner.
module tb_calc_self_test;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  result_in;
  logic [3:0]  a_out, b_out, fail_a, fail_b;
  logic [1:0]  op_out, fail_op;
  logic        busy, done, pass;
  logic [10:0] err_count;
  logic [7:0]  fail_result;

  logic        start_s = 1'b0;
  logic [7:0]  res_s = 8'd0;
  logic [3:0]  a_s, b_s, fa_s, fb_s;
  logic [1:0]  op_s, fop_s;
  logic        busy_s, done_s, pass_s;
  logic [10:0] err_s;
  logic [7:0]  fres_s;

  int mode = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  calc_self_test dut (
    .clk(clk), .reset(reset), .start(start), .result_in(result_in),
    .a_out(a_out), .b_out(b_out), .op_out(op_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_a(fail_a), .fail_b(fail_b), .fail_op(fail_op),
    .fail_result(fail_result)
  );

  calc_self_test #(.SETTLE_CYCLES(1), .NUM_VECTORS(1)) dut_small (
    .clk(clk), .reset(reset), .start(start_s), .result_in(res_s),
    .a_out(a_s), .b_out(b_s), .op_out(op_s), .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_count(err_s), .fail_a(fa_s), .fail_b(fb_s), .fail_op(fop_s), .fail_result(fres_s)
  );

  // Calculator under test: mode 0 correct, 1 single add fault, 2 div-by-zero returns 0.
  function automatic logic [7:0] calc(input logic [3:0] a, input logic [3:0] b,
                                      input logic [1:0] op, input int m);
    logic [7:0] r;
    case (op)
      2'b00: begin
        r = 8'(a) + 8'(b);
        if (m == 1 && a == 4'd3 && b == 4'd2) r = r + 8'd1;
      end
      2'b01: r = 8'(a) - 8'(b);
      2'b10: r = 8'(a) * 8'(b);
      default: r = (b == 4'd0) ? ((m == 2) ? 8'h00 : 8'hFF) : 8'(a / b);
    endcase
    return r;
  endfunction

  always_comb result_in = calc(a_out, b_out, op_out, mode);

  function automatic logic [63:0] all_out();
    return 64'({a_out, b_out, op_out, busy, done, pass, err_count, fail_a, fail_b,
                fail_op, fail_result});
  endfunction

  function automatic logic [63:0] all_out_s();
    return 64'({a_s, b_s, op_s, busy_s, done_s, pass_s, err_s, fa_s, fb_s, fop_s, fres_s});
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Counts negedges after E0 until done; busy_low counts pre-done cycles with busy=0.
  task automatic wait_done(output int cycles, output int busy_low);
    cycles = 0;
    busy_low = 0;
    while (!done && cycles < 5000) begin
      if (!busy) busy_low++;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic wait_vector(input int v, inout int cyc);
    while (int'({op_out, a_out, b_out}) != v && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  typedef struct {
    int          mode;
    int          err;
    logic [3:0]  fa;
    logic [3:0]  fb;
    logic [1:0]  fop;
    logic [7:0]  fres;
    logic        pass;
  } vec_t;

  vec_t tbl[3];

  initial begin
    int cyc, blow;
    tbl[0] = '{mode: 0, err: 0,  fa: 4'd0, fb: 4'd0, fop: 2'b00, fres: 8'h00, pass: 1'b1};
    tbl[1] = '{mode: 1, err: 1,  fa: 4'd3, fb: 4'd2, fop: 2'b00, fres: 8'h06, pass: 1'b0};
    tbl[2] = '{mode: 2, err: 16, fa: 4'd0, fb: 4'd0, fop: 2'b11, fres: 8'h00, pass: 1'b0};

    // Reset and idle after release.
    repeat (3) @(negedge clk);
    check("reset_outputs", all_out(), 64'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_after_release", all_out(), 64'd0);

    for (int i = 0; i < 3; i++) begin
      mode = tbl[i].mode;
      pulse_start();
      check($sformatf("v%0d_start_busy", i), {busy, done, pass}, 3'b100);
      check($sformatf("v%0d_start_clear", i), err_count, 0);
      wait_done(cyc, blow);
      check($sformatf("v%0d_done_cycle", i), cyc, 4096);
      check($sformatf("v%0d_busy_gaps", i), blow, 0);
      check($sformatf("v%0d_flags", i), {busy, done, pass}, {2'b01, tbl[i].pass});
      check($sformatf("v%0d_err_count", i), err_count, tbl[i].err);
      check($sformatf("v%0d_fail_vec", i), {fail_a, fail_b, fail_op, fail_result},
            {tbl[i].fa, tbl[i].fb, tbl[i].fop, tbl[i].fres});
      check($sformatf("v%0d_last_vec", i), {a_out, b_out, op_out}, {4'd15, 4'd15, 2'b11});
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_hold", i), {done, err_count}, {1'b1, 11'(tbl[i].err)});
    end

    // start pulsed mid-sweep is ignored.
    mode = 0;
    pulse_start();
    cyc = 0;
    wait_vector(100, cyc);
    check("reached_vec100", {op_out, a_out, b_out}, 10'd100);
    start = 1'b1;
    @(negedge clk);
    cyc++;
    start = 1'b0;
    check("busy_after_pulse", busy, 1'b1);
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check("pulse_done_cycle", cyc, 4096);
    check("pulse_pass", {pass, err_count}, {1'b1, 11'd0});

    // Reset mid-sweep clears asynchronously, then a fresh sweep runs from vector 0.
    pulse_start();
    cyc = 0;
    wait_vector(200, cyc);
    check("reached_vec200", {op_out, a_out, b_out}, 10'd200);
    #2 reset = 1'b0;
    #1 check("async_reset", all_out(), 64'd0);
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_abort", all_out(), 64'd0);
    pulse_start();
    check("restart_vec0", {busy, op_out, a_out, b_out}, {1'b1, 10'd0});
    wait_done(cyc, blow);
    check("restart_done_cycle", cyc, 4096);
    check("restart_pass", {done, pass, err_count}, {2'b11, 11'd0});

    // Single vector, single settle cycle.
    res_s = 8'h00;
    @(negedge clk) start_s = 1'b1;
    @(negedge clk) start_s = 1'b0;
    check("small_busy", {busy_s, done_s, a_s, b_s, op_s}, {2'b10, 10'd0});
    @(negedge clk);
    check("small_pass", {busy_s, done_s, pass_s, err_s}, {3'b011, 11'd0});
    res_s = 8'h5A;
    @(negedge clk) start_s = 1'b1;
    @(negedge clk) start_s = 1'b0;
    check("small_restart_clear", {busy_s, done_s, err_s}, {2'b10, 11'd0});
    @(negedge clk);
    check("small_fail", {done_s, pass_s, err_s, fres_s}, {2'b10, 11'd1, 8'h5A});
    check("small_all", all_out_s(),
          64'({4'd0, 4'd0, 2'd0, 3'b010, 11'd1, 4'd0, 4'd0, 2'd0, 8'h5A}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
